// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks the register file through its debug read port and
// streams every word, MSB byte first, into a byte-wide UART TX handshake.
//
// Handshake: o_tx_start is a one-cycle launch pulse that qualifies
// o_tx_data. The transmitter answers with a one-cycle i_tx_done once that
// byte has left, and o_tx_data stays stable until then. i_tx_done is only
// honoured in WAIT, and never in the cycle where o_tx_start is high.
module reg_dump_unit #(
    parameter int REGS  = 5,
    parameter int NBITS = 32,
    parameter int TAM   = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [NBITS-1:0] i_reg_data,
    input  logic             i_tx_done,
    output logic [REGS-1:0]  o_reg_addr,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       dbg_state
);

    localparam int BYTES = NBITS / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0]   LAST_BYTE = CW'(BYTES - 1);
    localparam logic [REGS-1:0] LAST_ADDR = REGS'(TAM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [NBITS-1:0] shift, shift_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [REGS-1:0]  addr_n;
    logic [7:0]       data_n;
    logic             start_n, busy_n, done_n;

    assign dbg_state = state;

    // State and all registered outputs; reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= S_IDLE;
            shift      <= '0;
            cnt        <= '0;
            o_reg_addr <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            cnt        <= cnt_n;
            o_reg_addr <= addr_n;
            o_tx_data  <= data_n;
            o_tx_start <= start_n;
            o_busy     <= busy_n;
            o_done     <= done_n;
        end
    end

    // Next-state and next-output decode; pulses default low each cycle.
    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = cnt;
        addr_n  = o_reg_addr;
        data_n  = o_tx_data;
        start_n = 1'b0;
        busy_n  = o_busy;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    addr_n  = '0;
                    busy_n  = 1'b1;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                // Address has been driven for a full cycle by now.
                shift_n = i_reg_data;
                cnt_n   = '0;
                state_n = S_SEND;
            end
            S_SEND: begin
                data_n  = shift[NBITS-1 -: 8];
                start_n = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // A done coinciding with the launch pulse belongs to no byte.
                if (i_tx_done && !o_tx_start) begin
                    if (cnt != LAST_BYTE) begin
                        shift_n = shift << 8;
                        cnt_n   = cnt + CW'(1);
                        state_n = S_SEND;
                    end else if (o_reg_addr != LAST_ADDR) begin
                        addr_n  = o_reg_addr + REGS'(1);
                        state_n = S_LOAD;
                    end else begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
